// File: rtl/cla_pkg.sv
// Shared types and constants for the carry-lookahead accumulator slice.
// Holds the FSM state encoding, datapath width and saturation limits.
package cla_pkg;

    localparam int ACC_W = 16;

    localparam logic [ACC_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [ACC_W-1:0] SAT_NEG = 16'h8000;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_e;

    // Clamp value chosen by the sign of the running total before the overflowing add.
    function automatic logic [ACC_W-1:0] sat_value(input logic neg);
        return neg ? SAT_NEG : SAT_POS;
    endfunction

endpackage

// File: rtl/cla_16bit.sv
// 16-bit two-level carry-lookahead adder: four 4-bit groups, with group
// generate/propagate combined by a second lookahead stage.
module cla_16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);

    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  gp;
    logic [3:0]  gg;
    logic [4:0]  gc;

    always_comb begin
        p  = a_i ^ b_i;
        g  = a_i & b_i;
        gp = '0;
        gg = '0;
        gc = '0;
        c  = '0;

        for (int k = 0; k < 4; k++) begin
            gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end

        // Group carries come straight from cin, not rippled group to group.
        gc[0] = cin_i;
        gc[1] = gg[0] | (gp[0] & cin_i);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin_i);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin_i);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & cin_i);

        for (int k = 0; k < 4; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end

        sum_o  = p ^ c;
        cout_o = gc[4];
    end

endmodule

// File: rtl/cla_accum16.sv
// Block accumulator behind a cla_16bit: sums BLOCK_LEN samples (or up to a flush)
// and hands the total plus sticky carry/overflow flags out on a valid/ready port.
module cla_accum16
    import cla_pkg::*;
#(
    parameter int BLOCK_LEN = 8,
    parameter bit SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_data,
    input  logic             in_sub,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic [7:0]       out_count
);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [7:0]       out_count_q, out_count_d;
    logic             out_carry_q, out_carry_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0] add_b;
    logic [ACC_W-1:0] add_sum;
    logic             add_cout;
    logic             add_v;
    logic [ACC_W-1:0] acc_nx;
    logic             accept;
    logic             last_beat;

    // Subtraction is a + ~x + 1, so the carry-in doubles as the subtract select.
    assign add_b = in_sub ? ~in_data : in_data;

    cla_16bit u_add (
        .a_i    (acc_q),
        .b_i    (add_b),
        .cin_i  (in_sub),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    assign add_v     = (acc_q[ACC_W-1] == add_b[ACC_W-1]) & (add_sum[ACC_W-1] != acc_q[ACC_W-1]);
    assign acc_nx    = (SATURATE && add_v) ? sat_value(acc_q[ACC_W-1]) : add_sum;
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid & in_ready;
    assign last_beat = (cnt_q == 8'(BLOCK_LEN - 1));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_carry_d = out_carry_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            ACC: begin
                if (accept) begin
                    acc_d   = acc_nx;
                    cnt_d   = cnt_q + 8'd1;
                    carry_d = carry_q | add_cout;
                    ovf_d   = ovf_q | add_v;
                end
                // A flush on an empty block has nothing to report and is dropped.
                if ((accept && (last_beat || flush)) || (!accept && flush && (cnt_q != 8'd0))) begin
                    state_d     = DONE;
                    out_sum_d   = acc_d;
                    out_count_d = cnt_d;
                    out_carry_d = carry_d;
                    out_ovf_d   = ovf_d;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_carry_q <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_carry_q <= out_carry_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_carry = out_carry_q;
    assign out_ovf   = out_ovf_q;

endmodule
